atctlc2axi500_burst_rr_arb: RTL and testbench

//  N-way burst-locking arbiter for the TLC-to-AXI request path, selectable fixed-priority or round-robin.

---
 rtl/atctlc2axi500_burst_rr_arb.sv | 128 ++++++++++++
 tb/tb_atctlc2axi500_burst_rr_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atctlc2axi500_burst_rr_arb.sv
// Burst-locking N-way arbiter for the TLC-to-AXI request path.
// MODE=0 is fixed priority with index 0 highest; MODE=1 is round-robin.
// The optional burst length check is enabled by defining
// ATCTLC2AXI500_BURST_ARB_LEN_CHK_EN.
module atctlc2axi500_burst_rr_arb #(
    parameter int N     = 4,
    parameter int MODE  = 1,
    parameter int LEN_W = 8,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     valids,
    input  logic [N-1:0]     lasts,
    output logic [N-1:0]     readys,
    output logic [N-1:0]     grants,
    output logic [IDX_W-1:0] grant_idx,
    output logic             valid,
    input  logic             ready,
    output logic             locked,
    output logic [LEN_W-1:0] beat_cnt,
    input  logic [LEN_W-1:0] max_beats,
    output logic             len_err
);

    typedef enum logic {IDLE, LOCK} state_t;

    localparam logic [N-1:0]   ONE_N   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0] N_WIDE  = (IDX_W+1)'(N);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] lock_idx, lock_idx_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [LEN_W-1:0] beat_cnt_nxt;
    logic             len_err_nxt;

    logic [N-1:0]     cand, rot;
    logic [2*N-1:0]   rot_dbl;
    logic [IDX_W-1:0] eff_ptr, sel_idx, ptr_adv;
    logic [IDX_W:0]   pos_sum, adv_sum;
    logic             sel_any, hs, hs_last;
    logic [LEN_W-1:0] cnt_inc;

    // Candidate selection: rotate the request vector so the search always starts at bit 0.
    always_comb begin
        cand    = (state == LOCK) ? (valids & (ONE_N << lock_idx)) : valids;
        eff_ptr = (MODE == 1) ? rr_ptr : '0;
        rot_dbl = {cand, cand} >> eff_ptr;
        rot     = rot_dbl[N-1:0];
        sel_any = |rot;
        pos_sum = '0;
        // Descending scan so the lowest set position wins without an early exit.
        for (int p = N - 1; p >= 0; p--) begin
            if (rot[p]) pos_sum = {1'b0, eff_ptr} + (IDX_W+1)'(p);
        end
        if (pos_sum >= N_WIDE) pos_sum = pos_sum - N_WIDE;
        sel_idx = pos_sum[IDX_W-1:0];
    end

    // Grant and handshake outputs; ready passes straight through with no register stage.
    always_comb begin
        grants    = sel_any ? (ONE_N << sel_idx) : '0;
        grant_idx = sel_idx;
        valid     = |grants;
        readys    = grants & {N{ready}};
        hs        = valid & ready;
        hs_last   = |(grants & lasts);
        adv_sum   = {1'b0, sel_idx} + (IDX_W+1)'(1);
        ptr_adv   = (adv_sum == N_WIDE) ? '0 : adv_sum[IDX_W-1:0];
        cnt_inc   = (state == IDLE) ? LEN_W'(1) : ((&beat_cnt) ? beat_cnt : beat_cnt + 1'b1);
    end

    // Next-state logic for the lock FSM, pointer, beat counter and length error.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_nxt    = state;
        lock_idx_nxt = lock_idx;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        len_err_nxt  = 1'b0;
        if (hs) begin
            if (hs_last) begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
                if (MODE == 1) rr_ptr_nxt = ptr_adv;
            end else begin
                state_nxt    = LOCK;
                lock_idx_nxt = sel_idx;
                beat_cnt_nxt = cnt_inc;
`ifdef ATCTLC2AXI500_BURST_ARB_LEN_CHK_EN
                // Reaching the limit without a last beat aborts the burst and frees the channel.
                if ((max_beats != '0) && (cnt_inc == max_beats)) begin
                    state_nxt    = IDLE;
                    beat_cnt_nxt = '0;
                    len_err_nxt  = 1'b1;
                    if (MODE == 1) rr_ptr_nxt = ptr_adv;
                end
`endif
            end
        end
    end

`ifndef ATCTLC2AXI500_BURST_ARB_LEN_CHK_EN
    logic unused_max_beats;
    assign unused_max_beats = ^max_beats;
`endif

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state    <= state_nxt;
            lock_idx <= lock_idx_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            len_err  <= len_err_nxt;
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_atctlc2axi500_burst_rr_arb.sv
// Self-checking bench: a fixed-priority and a round-robin instance side by side.
// Expected (grant_idx, beat_cnt) per handshake are queued when stimulus is driven.
module tb_atctlc2axi500_burst_rr_arb;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic [7:0] max_beats;

    logic [3:0] valids0, lasts0, readys0, grants0;
    logic [1:0] grant_idx0;
    logic       valid0, ready0, locked0, len_err0;
    logic [7:0] beat_cnt0;

    logic [3:0] valids1, lasts1, readys1, grants1;
    logic [1:0] grant_idx1;
    logic       valid1, ready1, locked1, len_err1;
    logic [7:0] beat_cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    atctlc2axi500_burst_rr_arb #(.N(4), .MODE(0), .LEN_W(8), .IDX_W(2)) u_fixed (
        .clk(clk), .resetn(resetn), .valids(valids0), .lasts(lasts0), .readys(readys0),
        .grants(grants0), .grant_idx(grant_idx0), .valid(valid0), .ready(ready0),
        .locked(locked0), .beat_cnt(beat_cnt0), .max_beats(max_beats), .len_err(len_err0)
    );

    atctlc2axi500_burst_rr_arb #(.N(4), .MODE(1), .LEN_W(8), .IDX_W(2)) u_rr (
        .clk(clk), .resetn(resetn), .valids(valids1), .lasts(lasts1), .readys(readys1),
        .grants(grants1), .grant_idx(grant_idx1), .valid(valid1), .ready(ready1),
        .locked(locked1), .beat_cnt(beat_cnt1), .max_beats(max_beats), .len_err(len_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (valid0 && ready0) begin
                if (q0.size() == 0) check("hs0_unexpected", 1, 0);
                else begin
                    e = q0.pop_front();
                    check("hs0_idx", 32'(grant_idx0), 32'(e.idx));
                    check("hs0_cnt", 32'(beat_cnt0), 32'(e.cnt));
                end
            end
            if (valid1 && ready1) begin
                if (q1.size() == 0) check("hs1_unexpected", 1, 0);
                else begin
                    e = q1.pop_front();
                    check("hs1_idx", 32'(grant_idx1), 32'(e.idx));
                    check("hs1_cnt", 32'(beat_cnt1), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        resetn = 1'b0; max_beats = 8'd4;
        valids0 = 4'hF; lasts0 = 4'h0; ready0 = 1'b0;
        valids1 = 4'hF; lasts1 = 4'h0; ready1 = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_locked", 32'(locked1), 0);
        check("rst_cnt", 32'(beat_cnt1), 0);
        check("rst_idx", 32'(grant_idx1), 0);
        check("rst_len_err", 32'(len_err1), 0);
        step();
        resetn = 1'b1;
        valids0 = 4'h0;
        @(negedge clk);
        check("post_rst_grants", 32'(grants1), 32'h1);
        step();

        // Round-robin rotation, single-beat bursts
        lasts1 = 4'hF; ready1 = 1'b1;
        for (int i = 0; i < 5; i++) q1.push_back('{idx: 2'(i % 4), cnt: 8'd0});
        repeat (5) @(posedge clk);
        #1;
        ready1 = 1'b0;
        @(negedge clk);
        check("rr_no_lock", 32'(locked1), 0);
        check("rr_cnt", 32'(beat_cnt1), 0);
        step();
        valids1 = 4'h0; lasts1 = 4'h0;

        // Fixed priority: req2 3-beat burst holds off req0
        valids0 = 4'b0100; ready0 = 1'b1;
        q0.push_back('{idx: 2'd2, cnt: 8'd0});
        q0.push_back('{idx: 2'd2, cnt: 8'd1});
        q0.push_back('{idx: 2'd2, cnt: 8'd2});
        q0.push_back('{idx: 2'd0, cnt: 8'd0});
        @(negedge clk);
        check("fp_b1_grants", 32'(grants0), 32'b0100);
        step();
        valids0 = 4'b0101;
        @(negedge clk);
        check("fp_b2_grants", 32'(grants0), 32'b0100);
        check("fp_b2_cnt", 32'(beat_cnt0), 1);
        check("fp_b2_locked", 32'(locked0), 1);
        step();
        lasts0 = 4'b0100;
        @(negedge clk);
        check("fp_b3_grants", 32'(grants0), 32'b0100);
        check("fp_b3_cnt", 32'(beat_cnt0), 2);
        step();
        valids0 = 4'b0001; lasts0 = 4'b0001;
        @(negedge clk);
        check("fp_req0_grants", 32'(grants0), 32'b0001);
        check("fp_req0_cnt", 32'(beat_cnt0), 0);
        check("fp_req0_locked", 32'(locked0), 0);
        step();
        ready0 = 1'b0; valids0 = 4'h0; lasts0 = 4'h0;

        // Downstream stall mid-burst of req1 (rr pointer now at 1)
        valids1 = 4'b0010; ready1 = 1'b1;
        q1.push_back('{idx: 2'd1, cnt: 8'd0});
        @(negedge clk);
        step();
        ready1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_locked", 32'(locked1), 1);
            check("stall_cnt", 32'(beat_cnt1), 1);
            check("stall_readys", 32'(readys1), 0);
            check("stall_valid", 32'(valid1), 1);
            check("stall_grants", 32'(grants1), 32'b0010);
            step();
        end
        ready1 = 1'b1; lasts1 = 4'b0010;
        q1.push_back('{idx: 2'd1, cnt: 8'd1});
        @(negedge clk);
        step();
        ready1 = 1'b0; valids1 = 4'h0; lasts1 = 4'h0;

        // Locked req3 drops valid while req0 requests (rr pointer now at 2)
        valids1 = 4'b1000; ready1 = 1'b1;
        q1.push_back('{idx: 2'd3, cnt: 8'd0});
        @(negedge clk);
        step();
        valids1 = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drop_valid", 32'(valid1), 0);
            check("drop_grants", 32'(grants1), 0);
            check("drop_readys", 32'(readys1), 0);
            check("drop_locked", 32'(locked1), 1);
            step();
        end
        valids1 = 4'b1001; lasts1 = 4'b1000;
        q1.push_back('{idx: 2'd3, cnt: 8'd1});
        @(negedge clk);
        step();
        ready1 = 1'b0; lasts1 = 4'h0;
        @(negedge clk);
        check("wrap_idx", 32'(grant_idx1), 0);
        check("wrap_grants", 32'(grants1), 32'b0001);
        check("wrap_locked", 32'(locked1), 0);
        step();
        valids1 = 4'h0;

        // Burst length limit (rr pointer now at 0, req1 wins over req2)
`ifdef ATCTLC2AXI500_BURST_ARB_LEN_CHK_EN
        valids1 = 4'b0110; ready1 = 1'b1;
        for (int i = 0; i < 4; i++) q1.push_back('{idx: 2'd1, cnt: 8'(i)});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("lc_no_err", 32'(len_err1), 0);
            step();
        end
        lasts1 = 4'b0110;
        q1.push_back('{idx: 2'd2, cnt: 8'd0});
        @(negedge clk);
        check("lc_err_pulse", 32'(len_err1), 1);
        check("lc_unlocked", 32'(locked1), 0);
        check("lc_cnt", 32'(beat_cnt1), 0);
        check("lc_next_idx", 32'(grant_idx1), 2);
        step();
        ready1 = 1'b0; valids1 = 4'h0; lasts1 = 4'h0;
        @(negedge clk);
        check("lc_err_clear", 32'(len_err1), 0);
        step();
`else
        valids1 = 4'b0110; ready1 = 1'b1;
        for (int i = 0; i < 6; i++) q1.push_back('{idx: 2'd1, cnt: 8'(i)});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("nolc_no_err", 32'(len_err1), 0);
            step();
        end
        lasts1 = 4'b0010;
        q1.push_back('{idx: 2'd1, cnt: 8'd6});
        @(negedge clk);
        check("nolc_locked", 32'(locked1), 1);
        check("nolc_cnt", 32'(beat_cnt1), 6);
        step();
        ready1 = 1'b0; valids1 = 4'h0; lasts1 = 4'h0;
`endif

        // Reset asserted mid-burst on the fixed-priority instance
        valids0 = 4'b0010; ready0 = 1'b1;
        q0.push_back('{idx: 2'd1, cnt: 8'd0});
        @(negedge clk);
        step();
        ready0 = 1'b0;
        @(negedge clk);
        check("mid_locked", 32'(locked0), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_locked", 32'(locked0), 0);
        check("async_rst_cnt", 32'(beat_cnt0), 0);
        valids0 = 4'h0;
        step();
        resetn = 1'b1;
        @(negedge clk);
        check("after_rst_valid", 32'(valid0), 0);

        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
